div23_seq: RTL and testbench

Iterative controller that divides a 64-bit unsigned dividend by the constant 23, producing quotient and remainder. It sequences a small combinational constant-division step (remainder-update slice) over the dividend, STEP bits per cycle, behind valid/ready handshakes on input and output. It sits in the 64-bit divide-by-23 datapath as the area-lean alternative to the fully unrolled LUT cascade.

---
 rtl/div_const_pkg.sv | 30 +++
 rtl/div23_step.sv | 45 ++++
 rtl/div23_seq.sv | 141 ++++++++++++++
 tb/tb_div23_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_const_pkg.sv
// Shared constants, helpers and controller state encoding for the
// iterative divide-by-constant datapath.
//   W          dividend / quotient width
//   DIVISOR    constant divisor the step slice is generated for
//   rem_w()    remainder width for a given divisor
//   step_legal() legality of a bits-per-cycle choice
//   state_t    controller states
package div_const_pkg;

  localparam int unsigned W       = 64;
  localparam int unsigned DIVISOR = 23;

  // Remainder is always < divisor, so clog2(divisor) bits hold it.
  function automatic int unsigned rem_w(input int unsigned divisor);
    return $clog2(divisor);
  endfunction

  // Bits-per-cycle must be a small power of two that tiles the dividend.
  function automatic bit step_legal(input int unsigned w, input int unsigned step);
    return ((step == 1) || (step == 2) || (step == 4) || (step == 8)) &&
           ((w % step) == 0);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div23_step.sv
// Combinational remainder-update slice for division by a constant.
// Consumes STEP dividend bits (MSB first) against the running remainder and
// produces STEP quotient bits plus the updated remainder.
// Ports:
//   rem       in   REM_W  running remainder, always < DIVISOR
//   chunk     in   STEP   next dividend bits, MSB first
//   digit     out  STEP   quotient bits for this chunk
//   rem_next  out  REM_W  remainder after consuming chunk
module div23_step #(
  parameter  int unsigned DIVISOR = div_const_pkg::DIVISOR,
  parameter  int unsigned STEP    = 1,
  localparam int unsigned REM_W   = div_const_pkg::rem_w(DIVISOR)
) (
  input  logic [REM_W-1:0] rem,
  input  logic [STEP-1:0]  chunk,
  output logic [STEP-1:0]  digit,
  output logic [REM_W-1:0] rem_next
);

  localparam int unsigned TW = REM_W + 1;

  logic [REM_W-1:0] w_r;
  logic [TW-1:0]    w_t;

  // Restoring division unrolled over the chunk. Each partial value is below
  // 2*DIVISOR, so a single conditional subtract yields the digit; the whole
  // slice collapses to one function of REM_W+STEP inputs.
  always_comb begin
    w_r   = rem;
    w_t   = '0;
    digit = '0;
    for (int i = int'(STEP) - 1; i >= 0; i--) begin
      w_t = {w_r, chunk[i]};
      if (w_t >= TW'(DIVISOR)) begin
        digit[i] = 1'b1;
        w_r      = REM_W'(w_t - TW'(DIVISOR));
      end else begin
        // Below DIVISOR, so the top bit is zero.
        w_r = w_t[REM_W-1:0];
      end
    end
    rem_next = w_r;
  end

endmodule

// File: rtl/div23_seq.sv
// Iterative unsigned divide-by-constant controller. Shifts the dividend
// through a single remainder-update slice STEP bits per cycle; the quotient
// shifts into the same register the dividend leaves.
// Ports:
//   clk            in   1      clock, rising edge
//   rst            in   1      synchronous active-high reset
//   in_valid       in   1      dividend offered
//   in_ready       out  1      dividend can be accepted this cycle
//   in_dividend    in   W      unsigned dividend
//   out_valid      out  1      result held on out_quotient/out_remainder
//   out_ready      in   1      consumer takes result
//   out_quotient   out  W      floor(dividend / DIVISOR)
//   out_remainder  out  REM_W  dividend mod DIVISOR
//   busy           out  1      iteration in progress
module div23_seq #(
  parameter  int unsigned W       = div_const_pkg::W,
  parameter  int unsigned DIVISOR = div_const_pkg::DIVISOR,
  parameter  int unsigned STEP    = 1,
  localparam int unsigned REM_W   = div_const_pkg::rem_w(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_dividend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_quotient,
  output logic [REM_W-1:0] out_remainder,
  output logic             busy
);

  import div_const_pkg::*;

  localparam int unsigned NSTEPS = W / STEP;
  localparam int unsigned CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  // Reject chunk sizes that do not tile the dividend.
  if (!step_legal(W, STEP)) begin : g_bad_step
    $error("div23_seq: STEP=%0d is not legal for W=%0d", STEP, W);
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_shreg;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic             w_load;
  logic             w_step;
  logic [STEP-1:0]  w_chunk;
  logic [STEP-1:0]  w_digit;
  logic [REM_W-1:0] w_rem_next;

  assign w_chunk = r_shreg[W-1 -: STEP];

  div23_step #(
    .DIVISOR (DIVISOR),
    .STEP    (STEP)
  ) u_step (
    .rem      (r_rem),
    .chunk    (w_chunk),
    .digit    (w_digit),
    .rem_next (w_rem_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus load/step strobes for the datapath.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Retiring and accepting in the same cycle keeps back-to-back
        // operations free of an idle bubble.
        if (out_ready) begin
          w_load       = in_valid;
          w_state_next = in_valid ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Shared dividend/quotient shifter, running remainder and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_shreg <= in_dividend;
      r_rem   <= '0;
      r_cnt   <= CNT_W'(NSTEPS - 1);
    end else if (w_step) begin
      r_shreg <= {r_shreg[W-STEP-1:0], w_digit};
      r_rem   <= w_rem_next;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // Handshake and status decode from the state register; in_ready also
  // looks at out_ready while a result is waiting.
  assign in_ready      = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid     = (r_state == ST_DONE);
  assign busy          = (r_state == ST_RUN);
  assign out_quotient  = r_shreg;
  assign out_remainder = r_rem;

  // Remainder must stay a proper residue.
  a_rem_range : assert property (@(posedge clk) disable iff (rst)
    {1'b0, r_rem} < (REM_W + 1)'(DIVISOR));

  // A stalled result must not move.
  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_quotient) && $stable(out_remainder)));

endmodule

// File: tb/tb_div23_seq.sv
// Bench for div23_seq: one instance per legal STEP (1, 2, 4, 8), directed
// cases on STEP=1 and STEP=4, then concurrent random traffic on all four.
// Expected results are queued when a dividend is accepted and compared when
// the matching result is taken.
module tb_div23_seq;

  import div_const_pkg::*;

  localparam int unsigned NI = 4;
  localparam int unsigned RW = rem_w(DIVISOR);

  typedef struct packed {
    logic [63:0]   q;
    logic [RW-1:0] r;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid      [NI];
  logic          in_ready      [NI];
  logic [63:0]   in_dividend   [NI];
  logic          out_valid     [NI];
  logic          out_ready     [NI];
  logic [63:0]   out_quotient  [NI];
  logic [RW-1:0] out_remainder [NI];
  logic          busy          [NI];

  exp_t exp_next [NI];
  exp_t exp_q    [NI][$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    div23_seq #(.STEP(1 << g)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid[g]),
      .in_ready      (in_ready[g]),
      .in_dividend   (in_dividend[g]),
      .out_valid     (out_valid[g]),
      .out_ready     (out_ready[g]),
      .out_quotient  (out_quotient[g]),
      .out_remainder (out_remainder[g]),
      .busy          (busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Scoreboard: pop on retire, push on accept, flush on reset.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < int'(NI); k++) begin
      if (rst) begin
        exp_q[k].delete();
      end else begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            check_eq($sformatf("extra_result_s%0d", 1 << k), 64'(exp_q[k].size()), 64'd1);
          end else begin
            e = exp_q[k].pop_front();
            check_eq($sformatf("quot_s%0d", 1 << k), out_quotient[k], e.q);
            check_eq($sformatf("rem_s%0d", 1 << k), 64'(out_remainder[k]), 64'(e.r));
          end
        end
        if (in_valid[k] && in_ready[k]) begin
          exp_q[k].push_back(exp_next[k]);
        end
      end
    end
  end

  // Offer one dividend and hold it until accepted; returns the accept cycle.
  task automatic send(input int k, input logic [63:0] d, input logic [63:0] eq,
                      input logic [RW-1:0] er, output int acc);
    @(posedge clk); #1;
    exp_next[k]    = '{q: eq, r: er};
    in_dividend[k] = d;
    in_valid[k]    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready[k]) break;
    end
    acc = cyc;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  // Wait (bounded) for out_valid and check accept-to-valid latency.
  task automatic wait_valid(input int k, input int acc, input int lat, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid[k]) break;
    end
    check_eq(tag, 64'(cyc - acc), 64'(lat));
  endtask

  // Random dividends with random in_valid gaps and out_ready stalls.
  task automatic rand_run(input int k, input int n);
    int          sent  = 0;
    int          guard = 0;
    bit          took  = 1'b0;
    logic [63:0] d;
    while ((sent < n || exp_q[k].size() != 0) && guard < 40000) begin
      @(posedge clk); #1;
      guard++;
      if (took) begin
        in_valid[k] = 1'b0;
        took        = 1'b0;
      end
      out_ready[k] = ($urandom_range(0, 3) != 0);
      if (!in_valid[k] && sent < n && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 7))
          0:       d = '0;
          1:       d = '1;
          2:       d = 64'(DIVISOR - 1);
          3:       d = 64'(DIVISOR);
          default: d = {$urandom, $urandom};
        endcase
        in_dividend[k] = d;
        exp_next[k]    = '{q: d / 64'(DIVISOR), r: RW'(d % 64'(DIVISOR))};
        in_valid[k]    = 1'b1;
      end
      @(negedge clk);
      if (in_valid[k] && in_ready[k]) begin
        sent++;
        took = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    check_eq($sformatf("rand_sent_s%0d", 1 << k), 64'(sent), 64'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    for (int k = 0; k < int'(NI); k++) begin
      in_valid[k]    = 1'b0;
      in_dividend[k] = '0;
      out_ready[k]   = 1'b0;
      exp_next[k]    = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready",  64'(in_ready[0]), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check_eq("rst_busy",      64'(busy[0]), 64'd0);
    check_eq("rst_quot",      out_quotient[0], 64'd0);
    check_eq("rst_rem",       64'(out_remainder[0]), 64'd0);
    check_eq("rst_in_ready8", 64'(in_ready[3]), 64'd1);

    out_ready[0] = 1'b1;
    out_ready[2] = 1'b1;

    send(0, 64'd0, 64'd0, 5'd0, acc);       wait_valid(0, acc, 65, "lat_zero_s1");
    send(0, 64'd1000, 64'd43, 5'd11, acc);  wait_valid(0, acc, 65, "lat_1000_s1");
    send(0, 64'd22, 64'd0, 5'd22, acc);     wait_valid(0, acc, 65, "lat_22_s1");
    send(0, 64'd23, 64'd1, 5'd0, acc);      wait_valid(0, acc, 65, "lat_23_s1");
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd802032351030850070, 5'd5, acc);
    wait_valid(0, acc, 65, "lat_max_s1");
    send(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd802032351030850070, 5'd5, acc);
    wait_valid(2, acc, 17, "lat_max_s4");

    // Backpressure: result held, second dividend refused until retire.
    out_ready[0] = 1'b0;
    send(0, 64'd1000, 64'd43, 5'd11, acc);
    wait_valid(0, acc, 65, "lat_bp");
    @(posedge clk); #1;
    in_dividend[0] = 64'd777;
    exp_next[0]    = '{q: 64'd33, r: 5'd18};
    in_valid[0]    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready",  64'(in_ready[0]), 64'd0);
      check_eq("bp_out_valid", 64'(out_valid[0]), 64'd1);
      check_eq("bp_quot",      out_quotient[0], 64'd43);
      check_eq("bp_rem",       64'(out_remainder[0]), 64'd11);
      @(posedge clk); #1;
    end
    in_dividend[0] = 64'd5000;
    exp_next[0]    = '{q: 64'd217, r: 5'd9};
    out_ready[0]   = 1'b1;
    @(negedge clk);
    check_eq("bp_retire_accept", 64'(in_ready[0]), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_valid(0, acc, 65, "lat_after_bp");

    // Reset in the middle of an iteration discards it.
    send(0, 64'd12345, 64'd536, 5'd17, acc);
    repeat (28) @(posedge clk);
    @(negedge clk);
    check_eq("run_busy", 64'(busy[0]), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_in_ready",  64'(in_ready[0]), 64'd1);
    check_eq("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
    check_eq("mid_rst_busy",      64'(busy[0]), 64'd0);
    check_eq("mid_rst_quot",      out_quotient[0], 64'd0);
    check_eq("mid_rst_rem",       64'(out_remainder[0]), 64'd0);
    send(0, 64'd46, 64'd2, 5'd0, acc);
    wait_valid(0, acc, 65, "lat_46_s1");

    fork
      rand_run(0, 200);
      rand_run(1, 200);
      rand_run(2, 200);
      rand_run(3, 200);
    join

    repeat (2) @(posedge clk);
    for (int k = 0; k < int'(NI); k++) begin
      check_eq($sformatf("sb_left_s%0d", 1 << k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
